// File: rtl/trace_pkg.sv
// Shared types for the trace checker: entry kinds, entry layout, counter width
// and the compare rule used by the checker core.
package trace_pkg;
    localparam int CNT_W  = 16;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        KIND_REG   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2,
        KIND_HALT  = 2'd3
    } kind_e;

    typedef struct packed {
        kind_e             kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // REG compares only the register index bits; HALT compares kind only.
    function automatic logic entry_match(entry_t ev, entry_t ex);
        if (ev.kind != ex.kind) return 1'b0;
        case (ev.kind)
            KIND_REG:  return (ev.addr[2:0] == ex.addr[2:0]) && (ev.data == ex.data);
            KIND_HALT: return 1'b1;
            default:   return (ev.addr == ex.addr) && (ev.data == ex.data);
        endcase
    endfunction

    function automatic cnt_t sat_inc(cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction
endpackage

// File: rtl/trace_checker_if.sv
// Golden-trace channel and DUT commit bus seen by the trace checker.
interface trace_checker_if;
    logic        exp_valid;
    logic        exp_ready;
    logic [1:0]  exp_kind;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
    logic        reg_wr;
    logic [2:0]  reg_sel;
    logic [15:0] reg_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] mem_wdata;
    logic        halt;

    modport master (
        output exp_valid, exp_kind, exp_addr, exp_data,
        output reg_wr, reg_sel, reg_data,
        output mem_rd, mem_wr, mem_addr, mem_rdata, mem_wdata, halt,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_kind, exp_addr, exp_data,
        input  reg_wr, reg_sel, reg_data,
        input  mem_rd, mem_wr, mem_addr, mem_rdata, mem_wdata, halt,
        output exp_ready
    );
endinterface

// File: rtl/trace_evq.sv
// Commit-event queue: up to four compacted pushes and one pop per cycle.
// A cycle whose pushes do not all fit is dropped as a whole.
module trace_evq
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             push,
    input  entry_t [3:0]           push_entry,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf
);
    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    n_push;
    logic [PW:0]   free;
    logic          accept;
    logic [PW-1:0] slot [4];

    // Each valid push lands after the valid pushes ahead of it in fixed order.
    always_comb begin
        n_push = 3'd0;
        for (int i = 0; i < 4; i++) begin
            slot[i] = wr_ptr + PW'(n_push);
            n_push  = n_push + {2'b00, push[i]};
        end
        free   = (PW+1)'(DEPTH) - count;
        accept = ((PW+1)'(n_push) <= free);
    end

    assign ovf   = !accept;
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(n_push);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            count <= count + (accept ? (PW+1)'(n_push) : '0) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) mem[slot[i]] <= push_entry[i];
            end
        end
    end
endmodule

// File: rtl/trace_checker.sv
// Compares DUT commit events against a golden trace, one pair per cycle,
// and reports counters plus an end-of-check pass/fail verdict.
module trace_checker
    import trace_pkg::*;
#(
    parameter int EVQ_DEPTH = 8,
    parameter int EXP_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    trace_checker_if.slave bus,
    output logic           mismatch,
    output cnt_t           match_cnt,
    output cnt_t           mismatch_cnt,
    output cnt_t           inst_cnt,
    output logic           overflow,
    output logic           underflow,
    output logic           done,
    output logic           pass
);
    localparam int EW = $clog2(EXP_DEPTH);
    localparam int QW = $clog2(EVQ_DEPTH) + 1;

    state_e        state;
    logic          ready_en;
    logic          last_halt_ok;

    entry_t        exp_mem [EXP_DEPTH];
    logic [EW-1:0] exp_wr;
    logic [EW-1:0] exp_rd;
    logic [EW:0]   exp_count;
    logic          exp_full;
    logic          exp_empty;
    logic          exp_push;

    logic          run;
    logic [3:0]    ev_push;
    entry_t [3:0]  ev_entry;
    entry_t        ev_head;
    logic          ev_empty;
    logic [QW-1:0] ev_count;
    logic          ev_ovf;

    logic          cmp;
    logic          cmp_ok;
    logic          cmp_halt_ok;
    logic          ev_last;
    logic          halt_ok_now;
    logic          clean_now;

    assign run     = (state == ST_RUN);
    assign ev_push = run ? {bus.halt, bus.mem_wr, bus.mem_rd, bus.reg_wr} : 4'b0000;

    always_comb begin
        ev_entry[0] = '{kind: KIND_REG,   addr: {13'd0, bus.reg_sel}, data: bus.reg_data};
        ev_entry[1] = '{kind: KIND_LOAD,  addr: bus.mem_addr,         data: bus.mem_rdata};
        ev_entry[2] = '{kind: KIND_STORE, addr: bus.mem_addr,         data: bus.mem_wdata};
        ev_entry[3] = '{kind: KIND_HALT,  addr: '0,                   data: '0};
    end

    trace_evq #(.DEPTH(EVQ_DEPTH)) u_evq (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ev_push),
        .push_entry (ev_entry),
        .pop        (cmp),
        .head       (ev_head),
        .empty      (ev_empty),
        .count      (ev_count),
        .ovf        (ev_ovf)
    );

    // ready_en holds exp_ready low through reset and until the first edge after it.
    assign exp_full      = (exp_count == (EW+1)'(EXP_DEPTH));
    assign exp_empty     = (exp_count == '0);
    assign bus.exp_ready = ready_en && !exp_full && (state != ST_DONE);
    assign exp_push      = bus.exp_valid && bus.exp_ready;

    assign cmp         = !ev_empty && !exp_empty && (state != ST_DONE);
    assign cmp_ok      = entry_match(ev_head, exp_mem[exp_rd]);
    assign cmp_halt_ok = cmp_ok && (ev_head.kind == KIND_HALT);
    assign ev_last     = cmp && (ev_count == QW'(1));

    // Verdict folds in a compare that retires the final event this same cycle.
    assign halt_ok_now = cmp ? cmp_halt_ok : last_halt_ok;
    assign clean_now   = (mismatch_cnt == '0) && !(cmp && !cmp_ok) && !overflow && !underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_wr    <= '0;
            exp_rd    <= '0;
            exp_count <= '0;
        end else begin
            if (exp_push) exp_wr <= exp_wr + EW'(1);
            if (cmp)      exp_rd <= exp_rd + EW'(1);
            exp_count <= exp_count + (EW+1)'(exp_push) - (EW+1)'(cmp);
        end
    end

    always_ff @(posedge clk) begin
        if (exp_push)
            exp_mem[exp_wr] <= '{kind: kind_e'(bus.exp_kind), addr: bus.exp_addr, data: bus.exp_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            ready_en     <= 1'b0;
            last_halt_ok <= 1'b0;
            mismatch     <= 1'b0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            inst_cnt     <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            mismatch <= cmp && !cmp_ok;
            if (cmp) begin
                if (cmp_ok) match_cnt    <= sat_inc(match_cnt);
                else        mismatch_cnt <= sat_inc(mismatch_cnt);
                last_halt_ok <= cmp_halt_ok;
            end
            if (run && (bus.halt || bus.reg_wr || bus.mem_wr))
                inst_cnt <= sat_inc(inst_cnt);
            if (ev_ovf)
                overflow <= 1'b1;
            case (state)
                ST_RUN: begin
                    if (bus.halt && !ev_ovf) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (ev_empty || ev_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        pass  <= clean_now && halt_ok_now;
                    end else if (exp_empty) begin
                        state     <= ST_DONE;
                        underflow <= 1'b1;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
